// File: rtl/fetch_queue_pkg.sv
// -----------------------------------------------------------------------------
// fetch_queue_pkg
//  Shared constants, the queue-entry record and a dequeue-clamp helper for the
//  dual-issue fetch queue.
//  Contents:
//    INSTR_W, PC_W       instruction and PC widths (32)
//    DEFAULT_RESET_PC    default fetch PC after reset
//    NOP                 value shown on instruction outputs when not valid
//    fq_entry_t          {pc, instr} record held in each queue slot
//    deq_clamp()         turns a decode request into the number actually popped
// -----------------------------------------------------------------------------
package fetch_queue_pkg;

   localparam int          INSTR_W          = 32;
   localparam int          PC_W             = 32;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
   localparam logic [31:0] NOP              = 32'h0000_0000;

   typedef struct packed {
      logic [PC_W-1:0]    pc;
      logic [INSTR_W-1:0] instr;
   } fq_entry_t;

   // A request of 3 is read as 2, and never more than 'avail' (min(count,2))
   // is popped, so the queue cannot underflow.
   function automatic logic [1:0] deq_clamp(input logic [1:0] req,
                                            input logic [1:0] avail);
      logic [1:0] want;
      want = (req == 2'd3) ? 2'd2 : req;
      return (want > avail) ? avail : want;
   endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// -----------------------------------------------------------------------------
// fetch_queue_if
//  Bundles the instruction-memory port, the redirect/decode controls and the
//  decode-facing queue head of the fetch queue.
//  Optional macro: FETCH_QUEUE_PERF_EN adds stall_cycles[31:0].
//  Modports:
//    master  - the fetch queue (drives imem addresses and queue-head outputs)
//    slave   - the environment (memory, decode, branch unit)
//  Signals:
//    imem_a/imem_b        word addresses of slot A / slot B
//    imem_rda/imem_rdb    instruction words returned for those addresses
//    redirect/redirect_pc flush and restart fetch at redirect_pc
//    deq_cnt              instructions consumed by decode this cycle
//    out_valid*/out_instr*/out_pc*  oldest two queue entries
//    count                occupied entries
// -----------------------------------------------------------------------------
interface fetch_queue_if #(
   parameter int AW    = 6,
   parameter int DEPTH = 8
);
   import fetch_queue_pkg::*;

   localparam int CW = $clog2(DEPTH) + 1;

   logic [AW-1:0]      imem_a;
   logic [AW-1:0]      imem_b;
   logic [INSTR_W-1:0] imem_rda;
   logic [INSTR_W-1:0] imem_rdb;
   logic               redirect;
   logic [PC_W-1:0]    redirect_pc;
   logic [1:0]         deq_cnt;
   logic               out_valid0;
   logic [INSTR_W-1:0] out_instr0;
   logic [PC_W-1:0]    out_pc0;
   logic               out_valid1;
   logic [INSTR_W-1:0] out_instr1;
   logic [PC_W-1:0]    out_pc1;
   logic [CW-1:0]      count;
`ifdef FETCH_QUEUE_PERF_EN
   logic [31:0]        stall_cycles;

   modport master (
      output imem_a, imem_b,
      input  imem_rda, imem_rdb,
      input  redirect, redirect_pc, deq_cnt,
      output out_valid0, out_instr0, out_pc0,
      output out_valid1, out_instr1, out_pc1,
      output count, stall_cycles
   );

   modport slave (
      input  imem_a, imem_b,
      output imem_rda, imem_rdb,
      output redirect, redirect_pc, deq_cnt,
      input  out_valid0, out_instr0, out_pc0,
      input  out_valid1, out_instr1, out_pc1,
      input  count, stall_cycles
   );
`else
   modport master (
      output imem_a, imem_b,
      input  imem_rda, imem_rdb,
      input  redirect, redirect_pc, deq_cnt,
      output out_valid0, out_instr0, out_pc0,
      output out_valid1, out_instr1, out_pc1,
      output count
   );

   modport slave (
      input  imem_a, imem_b,
      output imem_rda, imem_rdb,
      output redirect, redirect_pc, deq_cnt,
      input  out_valid0, out_instr0, out_pc0,
      input  out_valid1, out_instr1, out_pc1,
      input  count
   );
`endif

endinterface

// File: rtl/fq_store.sv
// -----------------------------------------------------------------------------
// fq_store
//  DEPTH x {pc,instr} queue storage. Two write ports at wr_ptr and wr_ptr+1,
//  two combinational read ports at rd_ptr and rd_ptr+1 (all modulo DEPTH).
//  Ports:
//    clk              rising-edge clock
//    wr_ptr           slot A write index (slot B writes the next index)
//    we_a / wa_data   slot A write enable / entry
//    we_b / wb_data   slot B write enable / entry
//    rd_ptr           oldest-entry index
//    rd0_data/rd1_data  entries at rd_ptr and rd_ptr+1
//  Storage carries no reset: every read is qualified by the queue count.
// -----------------------------------------------------------------------------
module fq_store
   import fetch_queue_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int PW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic [PW-1:0] wr_ptr,
   input  logic          we_a,
   input  fq_entry_t     wa_data,
   input  logic          we_b,
   input  fq_entry_t     wb_data,
   input  logic [PW-1:0] rd_ptr,
   output fq_entry_t     rd0_data,
   output fq_entry_t     rd1_data
);

   fq_entry_t     mem_r [DEPTH];
   logic [PW-1:0] wr_ptr_p1_s;
   logic [PW-1:0] rd_ptr_p1_s;

   // DEPTH is a power of two, so PW-bit addition wraps modulo DEPTH for free.
   assign wr_ptr_p1_s = wr_ptr + PW'(1);
   assign rd_ptr_p1_s = rd_ptr + PW'(1);

   // Slot writes; the two indices always differ because DEPTH >= 4.
   always_ff @(posedge clk) begin
      if (we_a) begin
         mem_r[wr_ptr] <= wa_data;
      end
      if (we_b) begin
         mem_r[wr_ptr_p1_s] <= wb_data;
      end
   end

   assign rd0_data = mem_r[rd_ptr];
   assign rd1_data = mem_r[rd_ptr_p1_s];

endmodule

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
//  Dual-issue instruction fetch stage with an in-order queue. Each cycle it
//  fetches up to two words (fetch_pc, fetch_pc+4) from a dual-read memory with
//  combinational return, writes as many as the registered free space allows,
//  and shows the two oldest entries to decode. A redirect flushes everything
//  and restarts fetch at the (word-aligned) target.
//  Parameters: DEPTH (power of 2, >= 4), AW (imem word-address width), RESET_PC
//  Ports:
//    clk    rising-edge clock
//    reset  asynchronous active-high reset
//    fq     fetch_queue_if.master (imem port, redirect, deq_cnt, queue head, count)
//  Optional macro: FETCH_QUEUE_PERF_EN adds a saturating stall_cycles counter.
// -----------------------------------------------------------------------------
module fetch_queue
   import fetch_queue_pkg::*;
#(
   parameter int          DEPTH    = 8,
   parameter int          AW       = 6,
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic          clk,
   input  logic          reset,
   fetch_queue_if.master fq
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [PC_W-1:0] fetch_pc_r;
   logic [PC_W-1:0] fetch_pc_p4_s;
   logic [PW-1:0]   wr_ptr_r;
   logic [PW-1:0]   rd_ptr_r;
   logic [CW-1:0]   count_r;
   logic [CW-1:0]   free_s;
   logic [1:0]      enq_s;
   logic [1:0]      avail_s;
   logic [1:0]      deq_eff_s;
   logic            we_a_s;
   logic            we_b_s;
   logic            valid0_s;
   logic            valid1_s;
   fq_entry_t       wa_data_s;
   fq_entry_t       wb_data_s;
   fq_entry_t       rd0_s;
   fq_entry_t       rd1_s;

   assign fetch_pc_p4_s = fetch_pc_r + 32'd4;

   // Free space comes from the registered count only; a same-cycle dequeue
   // does not open room for this cycle's fetch.
   assign free_s = CW'(DEPTH) - count_r;

   // Number of fetched words accepted this cycle.
   always_comb begin
      enq_s = 2'd0;
      if (free_s >= CW'(2)) begin
         enq_s = 2'd2;
      end else if (free_s == CW'(1)) begin
         enq_s = 2'd1;
      end else begin
         enq_s = 2'd0;
      end
   end

   // Entries decode could legally take this cycle, capped at two.
   always_comb begin
      avail_s = 2'd0;
      if (count_r >= CW'(2)) begin
         avail_s = 2'd2;
      end else if (count_r == CW'(1)) begin
         avail_s = 2'd1;
      end else begin
         avail_s = 2'd0;
      end
   end

   assign deq_eff_s = deq_clamp(fq.deq_cnt, avail_s);

   // A redirect suppresses this cycle's writes; the words in flight belong to
   // the abandoned path.
   assign we_a_s    = (enq_s != 2'd0) && !fq.redirect;
   assign we_b_s    = (enq_s == 2'd2) && !fq.redirect;
   assign wa_data_s = '{pc: fetch_pc_r,    instr: fq.imem_rda};
   assign wb_data_s = '{pc: fetch_pc_p4_s, instr: fq.imem_rdb};

   fq_store #(
      .DEPTH (DEPTH),
      .PW    (PW)
   ) u_store (
      .clk      (clk),
      .wr_ptr   (wr_ptr_r),
      .we_a     (we_a_s),
      .wa_data  (wa_data_s),
      .we_b     (we_b_s),
      .wb_data  (wb_data_s),
      .rd_ptr   (rd_ptr_r),
      .rd0_data (rd0_s),
      .rd1_data (rd1_s)
   );

   // Fetch PC, queue pointers and occupancy; redirect outranks enqueue/dequeue.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_pc_r <= RESET_PC;
         wr_ptr_r   <= '0;
         rd_ptr_r   <= '0;
         count_r    <= '0;
      end else if (fq.redirect) begin
         fetch_pc_r <= fq.redirect_pc & ~32'h0000_0003;
         wr_ptr_r   <= '0;
         rd_ptr_r   <= '0;
         count_r    <= '0;
      end else begin
         fetch_pc_r <= fetch_pc_r + {28'd0, enq_s, 2'b00};
         wr_ptr_r   <= wr_ptr_r + PW'(enq_s);
         rd_ptr_r   <= rd_ptr_r + PW'(deq_eff_s);
         count_r    <= count_r + CW'(enq_s) - CW'(deq_eff_s);
      end
   end

   // Word addresses simply truncate, so the memory index wraps at 2^AW words
   // while the stored PC keeps all 32 bits.
   assign fq.imem_a = fetch_pc_r[AW+1:2];
   assign fq.imem_b = fetch_pc_p4_s[AW+1:2];

   assign valid0_s      = (count_r != CW'(0));
   assign valid1_s      = (count_r >= CW'(2));
   assign fq.out_valid0 = valid0_s;
   assign fq.out_valid1 = valid1_s;
   assign fq.out_instr0 = valid0_s ? rd0_s.instr : NOP;
   assign fq.out_pc0    = valid0_s ? rd0_s.pc    : 32'h0000_0000;
   assign fq.out_instr1 = valid1_s ? rd1_s.instr : NOP;
   assign fq.out_pc1    = valid1_s ? rd1_s.pc    : 32'h0000_0000;
   assign fq.count      = count_r;

`ifdef FETCH_QUEUE_PERF_EN
   logic [31:0] stall_cycles_r;

   // Cycles where fetch could not take a full pair; redirect cycles excluded
   // and the count survives a redirect.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cycles_r <= 32'h0000_0000;
      end else if ((free_s < CW'(2)) && !fq.redirect
                   && (stall_cycles_r != 32'hFFFF_FFFF)) begin
         stall_cycles_r <= stall_cycles_r + 32'd1;
      end else begin
         stall_cycles_r <= stall_cycles_r;
      end
   end

   assign fq.stall_cycles = stall_cycles_r;
`endif

endmodule
